lut1_stim_checker: RTL
======================

LUT1_STIM_CHECKER -- requirements
Module: lut1_stim_checker

Interface
REQ-001 Parameter N_VEC, default 8, number of stimulus vectors applied per run (1..32).
REQ-002 Parameter PATTERN, default 32'h0000_00B2, stimulus bits; vector k uses PATTERN[k], k = 0..N_VEC-1.
REQ-003 Parameter SETTLE, default 4, clock cycles allowed for DUT propagation before sampling (1..255).
REQ-004 Parameter INVERT, default 1; expected dut_o = PATTERN[k] XOR INVERT.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle run request; honoured only in IDLE or DONE.
REQ-008 dut_o  input  1  LUT output under test; may be asynchronous to clk, double-flop synchronised internally.
REQ-009 dut_i  output  1  registered stimulus to LUT input.
REQ-010 busy  output  1  high from the cycle after an accepted start until DONE is entered.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  valid when done=1; high iff err_count = 0.
REQ-013 err_count  output  8  mismatches in current/last run, saturating at 255.
REQ-014 vec_idx  output  5  index of vector currently applied.

Function
REQ-015 FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE; encoding free.
REQ-016 IDLE/DONE + start=1 -> DRIVE; err_count, vec_idx cleared to 0 on that edge.
REQ-017 DRIVE (one cycle): dut_i <= PATTERN[vec_idx]; settle counter loaded with SETTLE; -> SETTLE.
REQ-018 SETTLE: counter decrements each cycle; at counter = 1 -> SAMPLE; stays exactly SETTLE cycles.
REQ-019 SAMPLE (one cycle): compare synchronised dut_o against PATTERN[vec_idx] XOR INVERT; mismatch increments err_count unless already 255.
REQ-020 SAMPLE with vec_idx = N_VEC-1 -> DONE; otherwise vec_idx increments -> DRIVE.
REQ-021 Per-vector period exactly SETTLE+2 cycles; full run N_VEC*(SETTLE+2) cycles from DRIVE entry to DONE entry.
REQ-022 start while busy ignored; no restart, no counter change.
REQ-023 dut_i holds its last value in DONE and IDLE until next DRIVE.
REQ-024 pass = done AND (err_count = 0); pass low whenever done low.
REQ-025 Synchroniser latency (2 cycles) counted within SETTLE; SETTLE < 3 is legal but the user owns the resulting sampling margin.
REQ-026 start asserted in DONE begins a new run on the same edge DONE is left; done deasserts next cycle.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, dut_i 0, busy 0, done 0, pass 0, err_count 0, vec_idx 0, synchroniser flops 0.
REQ-028 Reset asserted mid-run aborts the run; no partial result retained; after release block waits in IDLE for start.
REQ-029 Deassertion is synchronous to clk externally; first start accepted on the first rising edge with rst_n high.

Verification
REQ-030 Defaults, dut_o = NOT dut_i with 1-cycle delay, pulse start -> done after 48 cycles, pass=1, err_count=0, dut_i sequence 0,1,0,0,1,1,0,1.
REQ-031 Defaults, dut_o stuck at 1 -> done, pass=0, err_count=4 (vectors with PATTERN bit 1).
REQ-032 INVERT=0, dut_o = dut_i -> pass=1; same wiring with INVERT=1 -> err_count=8.
REQ-033 Reset pulsed at vector 3 SETTLE -> all outputs zero immediately; new start gives clean full run, pass=1.
REQ-034 start re-pulsed during busy -> ignored, total run length still 48 cycles; start pulsed in DONE -> new run, err_count cleared.
REQ-035 N_VEC=32, PATTERN=32'hFFFF_FFFF, SETTLE=255, INVERT=1, dut_o=dut_i -> err_count=32, done after 8224 cycles; separate 300-vector-equivalent stress with err forcing confirms 255 saturation.

Source files
------------

// File: rtl/lut1_stim_checker.sv
// Single-bit LUT stimulus/checker: drives PATTERN bits one at a time,
// waits SETTLE cycles, then compares the synchronised response.
module lut1_stim_checker #(
  parameter int unsigned N_VEC   = 8,
  parameter logic [31:0] PATTERN = 32'h0000_00B2,
  parameter int unsigned SETTLE  = 4,
  parameter bit          INVERT  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_o,
  output logic       dut_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [4:0] vec_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [7:0] SETTLE_W = 8'(SETTLE);
  localparam logic [4:0] LAST_IDX = 5'(N_VEC - 1);
  localparam logic [7:0] ERR_MAX  = 8'hFF;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] err_q, err_d;
  logic       din_q, din_d;
  logic       sync1_q, sync2_q;

  logic pat_bit;
  logic exp_bit;
  logic mismatch;

  assign pat_bit  = PATTERN[idx_q];
  assign exp_bit  = pat_bit ^ INVERT;
  assign mismatch = sync2_q != exp_bit;

  // dut_o may be asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= dut_o;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 5'd0;
      err_q   <= 8'd0;
      din_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    din_d   = din_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = 5'd0;
          err_d   = 8'd0;
        end
      end
      S_DRIVE: begin
        din_d   = pat_bit;
        cnt_d   = SETTLE_W;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (mismatch && err_q != ERR_MAX) begin
          err_d = err_q + 8'd1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_DRIVE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dut_i     = din_q;
  assign busy      = (state_q == S_DRIVE) ||
                     (state_q == S_SETTLE) ||
                     (state_q == S_SAMPLE);
  assign done      = state_q == S_DONE;
  assign pass      = done && (err_q == 8'd0);
  assign err_count = err_q;
  assign vec_idx   = idx_q;

endmodule
